vp_sequencer: RTL and testbench

VP_SEQUENCER -- requirements
Module: vp_sequencer

---
 rtl/vp_pkg.sv | 20 ++
 rtl/mips_core.svh | 7 +
 rtl/vp_step_counter.sv | 39 +++
 rtl/vp_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_vp_sequencer.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vp_pkg.sv
// Shared types and defaults for the value-prediction sequencer.
package vp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SPEC,
        HOLD,
        WAIT,
        RECOVER,
        FLUSH
    } vp_state_t;

    localparam int VP_NUM_REGS = 32;
    localparam int VP_TIMEOUT  = 1023;

    function automatic int vp_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mips_core.svh
// Core-wide widths shared by the MIPS pipeline blocks.
`ifndef MIPS_CORE_SVH
`define MIPS_CORE_SVH

`define MIPS_DATA_WIDTH 32

`endif

// File: rtl/vp_step_counter.sv
// Loadable up-counter shared by the fill watchdog and the restore-index walk.
module vp_step_counter #(
    parameter int WIDTH = 10,
    parameter int OUT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic [WIDTH-1:0] terminal_value,
    output logic [OUT_W-1:0] count,
    output logic             terminal
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (enable) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count    = count_q[OUT_W-1:0];
    assign terminal = (count_q == terminal_value);

endmodule

// File: rtl/vp_sequencer.sv
// Load-value speculation sequencer: predict on a D-cache miss, verify on fill,
// and on a wrong guess restore the register snapshot and refetch from the load.
`include "mips_core.svh"

module vp_sequencer
    import vp_pkg::*;
#(
    parameter int DATA_WIDTH = `MIPS_DATA_WIDTH,
    parameter int NUM_REGS   = VP_NUM_REGS,
    parameter int TIMEOUT    = VP_TIMEOUT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ld_miss,
    input  logic [DATA_WIDTH-1:0]       ld_addr,
    input  logic [DATA_WIDTH-1:0]       ld_pc,
    input  logic                        mem_op_ex,
    input  logic                        pred_valid,
    input  logic [DATA_WIDTH-1:0]       pred_data,
    input  logic                        dc_valid,
    input  logic [DATA_WIDTH-1:0]       dc_data,
    output logic                        hold_req_valid,
    output logic [DATA_WIDTH-1:0]       hold_req_addr,
    output logic                        spec_valid,
    output logic [DATA_WIDTH-1:0]       spec_data,
    output logic                        snapshot_take,
    output logic                        restore_we,
    output logic [$clog2(NUM_REGS)-1:0] restore_idx,
    output logic                        stall_all,
    output logic                        flush_all,
    output logic                        load_pc_we,
    output logic [DATA_WIDTH-1:0]       load_pc,
    output logic                        train_we,
    output logic [DATA_WIDTH-1:0]       train_pc,
    output logic [DATA_WIDTH-1:0]       train_data,
    output logic                        stat_hit,
    output logic                        stat_miss
);

    localparam int IDX_W = $clog2(NUM_REGS);
    localparam int CNT_W = vp_max($clog2(TIMEOUT + 1), IDX_W);

    vp_state_t             state_q, state_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] pred_q, pred_d;

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_value;
    logic             cnt_en;
    logic [CNT_W-1:0] cnt_term_value;
    logic [IDX_W-1:0] cnt_idx;
    logic             cnt_done;

    vp_step_counter #(
        .WIDTH (CNT_W),
        .OUT_W (IDX_W)
    ) u_step_counter (
        .clk            (clk),
        .rst            (rst),
        .load           (cnt_load),
        .load_value     (cnt_load_value),
        .enable         (cnt_en),
        .terminal_value (cnt_term_value),
        .count          (cnt_idx),
        .terminal       (cnt_done)
    );

    // Outputs are decoded from state and live inputs so the predicted value
    // reaches MEM in the same cycle as the miss; reset forces them all low.
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        pc_d           = pc_q;
        pred_d         = pred_q;
        cnt_load       = 1'b0;
        cnt_load_value = '0;
        cnt_en         = 1'b0;
        cnt_term_value = CNT_W'(TIMEOUT - 1);
        hold_req_valid = 1'b0;
        hold_req_addr  = '0;
        spec_valid     = 1'b0;
        spec_data      = '0;
        snapshot_take  = 1'b0;
        restore_we     = 1'b0;
        restore_idx    = '0;
        stall_all      = 1'b0;
        flush_all      = 1'b0;
        load_pc_we     = 1'b0;
        load_pc        = '0;
        train_we       = 1'b0;
        train_pc       = '0;
        train_data     = '0;
        stat_hit       = 1'b0;
        stat_miss      = 1'b0;

        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (ld_miss) begin
                        addr_d   = ld_addr;
                        pc_d     = ld_pc;
                        cnt_load = 1'b1;
                        if (pred_valid) begin
                            spec_valid    = 1'b1;
                            spec_data     = pred_data;
                            snapshot_take = 1'b1;
                            pred_d        = pred_data;
                            state_d       = SPEC;
                        end else begin
                            pred_d  = '0;
                            state_d = WAIT;
                        end
                    end
                end
                SPEC, HOLD: begin
                    hold_req_valid = 1'b1;
                    hold_req_addr  = addr_q;
                    stall_all      = (state_q == HOLD);
                    cnt_en         = 1'b1;
                    // A fill wins over both the watchdog and a second memory op.
                    if (dc_valid) begin
                        train_we   = 1'b1;
                        train_pc   = pc_q;
                        train_data = dc_data;
                        if (dc_data == pred_q) begin
                            stat_hit = 1'b1;
                            state_d  = IDLE;
                        end else begin
                            stat_miss      = 1'b1;
                            cnt_load       = 1'b1;
                            cnt_load_value = CNT_W'(1);
                            state_d        = RECOVER;
                        end
                    end else if (cnt_done) begin
                        stat_miss      = 1'b1;
                        cnt_load       = 1'b1;
                        cnt_load_value = CNT_W'(1);
                        state_d        = RECOVER;
                    end else if (state_q == SPEC && mem_op_ex) begin
                        state_d = HOLD;
                    end
                end
                WAIT: begin
                    hold_req_valid = 1'b1;
                    hold_req_addr  = addr_q;
                    stall_all      = 1'b1;
                    if (dc_valid) begin
                        spec_valid = 1'b1;
                        spec_data  = dc_data;
                        train_we   = 1'b1;
                        train_pc   = pc_q;
                        train_data = dc_data;
                        state_d    = IDLE;
                    end
                end
                RECOVER: begin
                    // Register 0 is hardwired, so the walk starts at index 1.
                    stall_all      = 1'b1;
                    restore_we     = 1'b1;
                    restore_idx    = cnt_idx;
                    cnt_en         = 1'b1;
                    cnt_term_value = CNT_W'(NUM_REGS - 1);
                    if (cnt_done) begin
                        state_d = FLUSH;
                    end
                end
                FLUSH: begin
                    flush_all  = 1'b1;
                    load_pc_we = 1'b1;
                    load_pc    = pc_q;
                    state_d    = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            pc_q    <= '0;
            pred_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            pc_q    <= pc_d;
            pred_q  <= pred_d;
        end
    end

endmodule

// File: tb/tb_vp_sequencer.sv
// Randomized bench for vp_sequencer: each load miss is expanded into an
// expected per-cycle timeline and compared against the DUT outputs.
module tb_vp_sequencer;

    localparam int DW = 32;
    localparam int NR = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ld_miss = 1'b0;
    logic [DW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_pc = '0;
    logic          mem_op_ex = 1'b0;
    logic          pred_valid = 1'b0;
    logic [DW-1:0] pred_data = '0;
    logic          dc_valid = 1'b0;
    logic [DW-1:0] dc_data = '0;
    logic          hold_req_valid;
    logic [DW-1:0] hold_req_addr;
    logic          spec_valid;
    logic [DW-1:0] spec_data;
    logic          snapshot_take;
    logic          restore_we;
    logic [4:0]    restore_idx;
    logic          stall_all;
    logic          flush_all;
    logic          load_pc_we;
    logic [DW-1:0] load_pc;
    logic          train_we;
    logic [DW-1:0] train_pc;
    logic [DW-1:0] train_data;
    logic          stat_hit;
    logic          stat_miss;

    int checks = 0;
    int passes = 0;

    vp_sequencer #(
        .DATA_WIDTH (DW),
        .NUM_REGS   (NR),
        .TIMEOUT    (TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ld_miss        (ld_miss),
        .ld_addr        (ld_addr),
        .ld_pc          (ld_pc),
        .mem_op_ex      (mem_op_ex),
        .pred_valid     (pred_valid),
        .pred_data      (pred_data),
        .dc_valid       (dc_valid),
        .dc_data        (dc_data),
        .hold_req_valid (hold_req_valid),
        .hold_req_addr  (hold_req_addr),
        .spec_valid     (spec_valid),
        .spec_data      (spec_data),
        .snapshot_take  (snapshot_take),
        .restore_we     (restore_we),
        .restore_idx    (restore_idx),
        .stall_all      (stall_all),
        .flush_all      (flush_all),
        .load_pc_we     (load_pc_we),
        .load_pc        (load_pc),
        .train_we       (train_we),
        .train_pc       (train_pc),
        .train_data     (train_data),
        .stat_hit       (stat_hit),
        .stat_miss      (stat_miss)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          hold_v;
        logic [DW-1:0] hold_a;
        logic          spec_v;
        logic [DW-1:0] spec_d;
        logic          snap;
        logic          rwe;
        logic [4:0]    ridx;
        logic          stall;
        logic          flush;
        logic          lpwe;
        logic [DW-1:0] lpc;
        logic          twe;
        logic [DW-1:0] tpc;
        logic [DW-1:0] tdata;
        logic          hit;
        logic          miss;
    } outs_t;

    // fill: cycle of dc_valid after the miss (0 = never); memop: cycle of mem_op_ex (0 = none)
    typedef struct {
        bit            pv;
        logic [DW-1:0] pd;
        logic [DW-1:0] dd;
        logic [DW-1:0] pc;
        logic [DW-1:0] addr;
        int            fill;
        int            memop;
    } txn_t;

    function automatic outs_t observe();
        outs_t o;
        o.hold_v = hold_req_valid;
        o.hold_a = hold_req_addr;
        o.spec_v = spec_valid;
        o.spec_d = spec_data;
        o.snap   = snapshot_take;
        o.rwe    = restore_we;
        o.ridx   = restore_idx;
        o.stall  = stall_all;
        o.flush  = flush_all;
        o.lpwe   = load_pc_we;
        o.lpc    = load_pc;
        o.twe    = train_we;
        o.tpc    = train_pc;
        o.tdata  = train_data;
        o.hit    = stat_hit;
        o.miss   = stat_miss;
        return o;
    endfunction

    function automatic bit filled(txn_t t);
        return (t.fill >= 1) && (t.fill <= TO);
    endfunction

    function automatic int resolve_cycle(txn_t t);
        return filled(t) ? t.fill : TO;
    endfunction

    function automatic bit is_hit(txn_t t);
        return filled(t) && (t.dd == t.pd);
    endfunction

    function automatic int txn_len(txn_t t);
        if (!t.pv) return t.fill + 2;
        return is_hit(t) ? resolve_cycle(t) + 2 : resolve_cycle(t) + NR + 2;
    endfunction

    // Expected outputs k cycles after the miss was presented in IDLE.
    function automatic outs_t expect_out(txn_t t, int k);
        outs_t e;
        int res;
        int r;
        e = '0;
        if (k == 0) begin
            if (t.pv) begin
                e.spec_v = 1'b1;
                e.spec_d = t.pd;
                e.snap   = 1'b1;
            end
            return e;
        end
        if (!t.pv) begin
            if (k <= t.fill) begin
                e.hold_v = 1'b1;
                e.hold_a = t.addr;
                e.stall  = 1'b1;
            end
            if (k == t.fill) begin
                e.spec_v = 1'b1;
                e.spec_d = t.dd;
                e.twe    = 1'b1;
                e.tpc    = t.pc;
                e.tdata  = t.dd;
            end
            return e;
        end
        res = resolve_cycle(t);
        if (k <= res) begin
            e.hold_v = 1'b1;
            e.hold_a = t.addr;
            e.stall  = (t.memop >= 1) && (t.memop < k);
            if (k == res) begin
                if (filled(t)) begin
                    e.twe   = 1'b1;
                    e.tpc   = t.pc;
                    e.tdata = t.dd;
                    e.hit   = is_hit(t);
                    e.miss  = !is_hit(t);
                end else begin
                    e.miss = 1'b1;
                end
            end
        end else if (!is_hit(t)) begin
            r = k - res;
            if (r <= NR - 1) begin
                e.rwe   = 1'b1;
                e.stall = 1'b1;
                e.ridx  = 5'(r);
            end else if (r == NR) begin
                e.flush = 1'b1;
                e.lpwe  = 1'b1;
                e.lpc   = t.pc;
            end
        end
        return e;
    endfunction

    task automatic drive_cycle(txn_t t, int k, int len);
        rst = 1'b0;
        if (k == 0) begin
            ld_miss    = 1'b1;
            ld_addr    = t.addr;
            ld_pc      = t.pc;
            pred_valid = t.pv;
            pred_data  = t.pd;
            mem_op_ex  = 1'($urandom_range(0, 1));
        end else begin
            ld_miss    = (k == len - 1) ? 1'b0 : 1'($urandom_range(0, 1));
            ld_addr    = $urandom;
            ld_pc      = $urandom;
            pred_valid = 1'($urandom_range(0, 1));
            pred_data  = $urandom;
            mem_op_ex  = (k == t.memop);
        end
        dc_valid = (k > 0) && (k == t.fill);
        dc_data  = dc_valid ? t.dd : $urandom;
    endtask

    function automatic txn_t make_txn(bit pv, logic [DW-1:0] pd, logic [DW-1:0] dd,
                                      logic [DW-1:0] pc, int fill, int memop);
        txn_t t;
        t.pv    = pv;
        t.pd    = pd;
        t.dd    = dd;
        t.pc    = pc;
        t.addr  = $urandom;
        t.fill  = fill;
        t.memop = memop;
        return t;
    endfunction

    task automatic test_reset();
        outs_t o;
        @(negedge clk);
        rst     = 1'b1;
        ld_miss = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            rst       = 1'b0;
            ld_miss   = 1'b0;
            mem_op_ex = 1'($urandom_range(0, 1));
            dc_valid  = 1'($urandom_range(0, 1));
            dc_data   = $urandom;
            #2;
            o = observe();
            checks++;
            if (o !== '0) $display("FAIL reset_idle i=%0d got=%h want=0", i, o);
            else passes++;
            @(negedge clk);
        end
    endtask

    task automatic test_hit();
        txn_t t;
        outs_t o, e;
        int len;
        t = make_txn(1'b1, 32'h1234, 32'h1234, $urandom, 3, 0);
        len = txn_len(t);
        for (int k = 0; k < len; k++) begin
            drive_cycle(t, k, len);
            #2;
            o = observe();
            e = expect_out(t, k);
            checks++;
            if (o !== e) $display("FAIL hit k=%0d got=%h want=%h", k, o, e);
            else passes++;
            @(negedge clk);
        end
    endtask

    task automatic test_mispredict();
        txn_t t;
        outs_t o, e;
        int len;
        t = make_txn(1'b1, 32'h1234, 32'h5678, 32'h400, 3, 0);
        len = txn_len(t);
        for (int k = 0; k < len; k++) begin
            drive_cycle(t, k, len);
            #2;
            o = observe();
            e = expect_out(t, k);
            checks++;
            if (o !== e) $display("FAIL mispredict k=%0d got=%h want=%h", k, o, e);
            else passes++;
            @(negedge clk);
        end
    endtask

    task automatic test_hold();
        txn_t t;
        outs_t o, e;
        int len;
        for (int n = 0; n < 2; n++) begin
            if (n == 0) t = make_txn(1'b1, 32'hA5A5, 32'hA5A5, $urandom, 4, 1);
            else        t = make_txn(1'b1, 32'hA5A5, 32'h5A5A, $urandom, 2, 2);
            len = txn_len(t);
            for (int k = 0; k < len; k++) begin
                drive_cycle(t, k, len);
                #2;
                o = observe();
                e = expect_out(t, k);
                checks++;
                if (o !== e) $display("FAIL hold n=%0d k=%0d got=%h want=%h", n, k, o, e);
                else passes++;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_no_pred();
        txn_t t;
        outs_t o, e;
        int len;
        t = make_txn(1'b0, $urandom, 32'hBEEF, $urandom, 3, 2);
        len = txn_len(t);
        for (int k = 0; k < len; k++) begin
            drive_cycle(t, k, len);
            #2;
            o = observe();
            e = expect_out(t, k);
            checks++;
            if (o !== e) $display("FAIL no_pred k=%0d got=%h want=%h", k, o, e);
            else passes++;
            @(negedge clk);
        end
    endtask

    task automatic test_watchdog();
        txn_t t;
        outs_t o, e;
        int len;
        for (int n = 0; n < 2; n++) begin
            // second case: the fill arrives late, during the recovery walk
            t = make_txn(1'b1, $urandom, $urandom, $urandom, (n == 0) ? 0 : TO + 2, 0);
            len = txn_len(t);
            for (int k = 0; k < len; k++) begin
                drive_cycle(t, k, len);
                #2;
                o = observe();
                e = expect_out(t, k);
                checks++;
                if (o !== e) $display("FAIL watchdog n=%0d k=%0d got=%h want=%h", n, k, o, e);
                else passes++;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset_mid();
        txn_t t;
        outs_t o, e;
        int len;
        int stop_k;
        for (int n = 0; n < 2; n++) begin
            t = make_txn(1'b1, 32'h1111, 32'h2222, $urandom, 2, 0);
            len = txn_len(t);
            stop_k = (n == 0) ? 2 + 10 : 2 + NR;
            for (int k = 0; k < stop_k; k++) begin
                drive_cycle(t, k, len);
                #2;
                o = observe();
                e = expect_out(t, k);
                checks++;
                if (o !== e) $display("FAIL reset_mid n=%0d k=%0d got=%h want=%h", n, k, o, e);
                else passes++;
                @(negedge clk);
            end
            drive_cycle(t, stop_k, len);
            rst = 1'b1;
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                rst       = 1'b0;
                ld_miss   = 1'b0;
                mem_op_ex = 1'($urandom_range(0, 1));
                dc_valid  = 1'($urandom_range(0, 1));
                dc_data   = $urandom;
                #2;
                o = observe();
                checks++;
                if (o !== '0) $display("FAIL reset_mid_idle n=%0d i=%0d got=%h want=0", n, i, o);
                else passes++;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_random();
        txn_t t;
        outs_t o, e;
        int len;
        bit pv;
        int fill;
        int sel;
        for (int n = 0; n < 40; n++) begin
            pv  = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 9);
            if (!pv)           fill = $urandom_range(1, 10);
            else if (sel == 0) fill = 0;
            else if (sel == 1) fill = TO + $urandom_range(1, 3);
            else               fill = $urandom_range(1, TO - 1);
            t = make_txn(pv, $urandom, $urandom, $urandom, fill, 0);
            if ($urandom_range(0, 1) == 1) t.dd = t.pd;
            t.memop = $urandom_range(0, pv ? resolve_cycle(t) : fill);
            len = txn_len(t);
            for (int k = 0; k < len; k++) begin
                drive_cycle(t, k, len);
                #2;
                o = observe();
                e = expect_out(t, k);
                checks++;
                if (o !== e) $display("FAIL random n=%0d k=%0d got=%h want=%h", n, k, o, e);
                else passes++;
                @(negedge clk);
            end
        end
    endtask

    initial begin
        test_reset();
        test_hit();
        test_reset_mid();
        test_mispredict();
        test_hold();
        test_no_pred();
        test_watchdog();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
